// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit for the EX stage (33-cycle iterative shift-add / restoring divide).
// Define MULDIV_FAST_MUL_EN to compute MUL* with a single-cycle combinational product instead.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [XLEN-1:0]   res_q, res_d;

    // Apply operand signs to the magnitude-domain product/quotient/remainder.
    function automatic logic [XLEN-1:0] finalize(input logic [2:0]        f3,
                                                 input logic [2*XLEN-1:0] acc,
                                                 input logic              sa,
                                                 input logic              sb);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = (sa ^ sb) ? -acc : acc;
        quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (f3[2])
            finalize = f3[1] ? rem : quo;
        else if (f3[1:0] == 2'b00)
            finalize = prod[XLEN-1:0];
        else
            finalize = prod[2*XLEN-1:XLEN];
    endfunction

    logic            is_div;
    logic            sgn_a_en, sgn_b_en;
    logic            sa_in, sb_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;

    assign is_div   = funct3[2];
    assign sgn_a_en = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    assign sgn_b_en = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign sa_in    = sgn_a_en & op_a[XLEN-1];
    assign sb_in    = sgn_b_en & op_b[XLEN-1];
    assign a_mag    = sa_in ? -op_a : op_a;
    assign b_mag    = sb_in ? -op_b : op_b;
    assign div_zero = is_div && (op_b == '0);
    assign div_ovf  = is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == ALL_ONES);

`ifdef MULDIV_FAST_MUL_EN
    // Low 64 bits of the sign-extended product are exact for every MUL* variant.
    logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
    logic [XLEN-1:0]   fast_res;
    assign fast_a   = {{XLEN{sa_in}}, op_a};
    assign fast_b   = {{XLEN{sb_in}}, op_b};
    assign fast_p   = fast_a * fast_b;
    assign fast_res = (funct3[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
`endif

    // acc_q holds {partial product | multiplier} or {remainder | dividend/quotient}.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_step;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign rem_ge   = rem_sh >= {1'b0, m_q};
    assign rem_diff = rem_sh[XLEN-1:0] - m_q;
    assign div_next = {(rem_ge ? rem_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
    assign acc_step = f3_q[2] ? div_next : mul_next;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        m_d     = m_q;
        acc_d   = acc_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        f3_d  = funct3;
                        sa_d  = sa_in;
                        sb_d  = sb_in;
                        cnt_d = '0;
                        m_d   = is_div ? b_mag : a_mag;
                        acc_d = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        if (div_zero) begin
                            res_d   = funct3[1] ? op_a : ALL_ONES;
                            state_d = DONE;
                        end else if (div_ovf) begin
                            res_d   = funct3[1] ? '0 : MIN_NEG;
                            state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div) begin
                            res_d   = fast_res;
                            state_d = DONE;
`endif
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        res_d   = finalize(f3_q, acc_step, sa_q, sb_q);
                        state_d = DONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
        end
    end

    assign stall        = !flush && ((state_q == IDLE && start) || state_q == BUSY);
    assign result_valid = !flush && (state_q == DONE);
    assign result       = res_q;

endmodule
